// File: rtl/apb_register_bank.sv
// apb_register_bank: parametrised register bank behind apb_interface, with RO mapping and error flagging.
// Define REG_BANK_W1C_EN to enable write-1-to-clear registers selected by W1C_MASK.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for wr/rd request; request fields latched on entry to WAIT/DONE
// ST_WAIT | access latency counter running down to zero
// ST_DONE | access committed on the exit edge; done/err pulse follows
module apb_register_bank #(
    parameter int                  DATA_W      = 8,
    parameter int                  ADDR_W      = 8,
    parameter int                  NUM_REGS    = 4,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RST_VAL     = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK    = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ADDR_W-1:0]          reg_addr_i,
    input  logic [DATA_W-1:0]          reg_data_i,
    output logic [DATA_W-1:0]          reg_data_o,
    input  logic                       reg_wr_en_i,
    input  logic                       reg_rd_en_i,
    output logic                       reg_wr_done_o,
    output logic                       reg_rd_done_o,
    output logic                       reg_err_o,
    input  logic [NUM_REGS*DATA_W-1:0] hw_status_i,
    input  logic [NUM_REGS*DATA_W-1:0] hw_set_i,
    output logic [NUM_REGS*DATA_W-1:0] reg_q_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

`ifdef REG_BANK_W1C_EN
    localparam logic [NUM_REGS-1:0] W1C_EFF = W1C_MASK;
`else
    localparam logic [NUM_REGS-1:0] W1C_EFF = '0;
`endif
    // W1C wins over RO for the same register index.
    localparam logic [NUM_REGS-1:0] RO_EFF     = RO_MASK & ~W1C_EFF;
    localparam int                  AW1        = ADDR_W + 1;
    localparam logic [ADDR_W:0]     NUM_REGS_A = AW1'(NUM_REGS);
    localparam logic [3:0]          WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                     state_q;
    state_t                     state_d;
    logic [3:0]                 wait_cnt_q;
    logic [ADDR_W-1:0]          addr_q;
    logic [DATA_W-1:0]          wdata_q;
    logic                       is_wr_q;
    logic                       req;
    logic                       commit_wr;
    logic                       commit_rd;
    logic                       addr_err;
    logic                       ro_hit;
    logic [DATA_W-1:0]          rd_sel;
    logic [NUM_REGS*DATA_W-1:0] rd_flat;
    logic                       unused_inputs;

    // Unused slices depend on the RO/W1C configuration; reduce them so nothing dangles.
    assign unused_inputs = ^{hw_status_i, hw_set_i, W1C_MASK};

    assign req       = reg_wr_en_i | reg_rd_en_i;
    assign commit_wr = (state_q == ST_DONE) &&  is_wr_q;
    assign commit_rd = (state_q == ST_DONE) && !is_wr_q;
    assign addr_err  = ({1'b0, addr_q} >= NUM_REGS_A);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Write has priority when both enables arrive together; the read is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            wait_cnt_q <= 4'd0;
        end else if ((state_q == ST_IDLE) && req) begin
            addr_q     <= reg_addr_i;
            wdata_q    <= reg_data_i;
            is_wr_q    <= reg_wr_en_i;
            wait_cnt_q <= WAIT_LOAD;
        end else if ((state_q == ST_WAIT) && (wait_cnt_q != 4'd0)) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
        end
    end

    always_comb begin
        rd_sel = '0;
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                rd_sel = rd_flat[i*DATA_W +: DATA_W];
                ro_hit = RO_EFF[i];
            end
        end
    end

    // Out-of-range reads match no register, so rd_sel already returns zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_data_o    <= '0;
            reg_wr_done_o <= 1'b0;
            reg_rd_done_o <= 1'b0;
            reg_err_o     <= 1'b0;
        end else begin
            reg_wr_done_o <= commit_wr;
            reg_rd_done_o <= commit_rd;
            reg_err_o     <= (commit_wr && (addr_err || ro_hit)) || (commit_rd && addr_err);
            if (commit_rd) begin
                reg_data_o <= rd_sel;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (RO_EFF[g]) begin : g_ro
            assign rd_flat[g*DATA_W +: DATA_W] = hw_status_i[g*DATA_W +: DATA_W];
            assign reg_q_o[g*DATA_W +: DATA_W] = '0;
        end else begin : g_rw
            logic              hit_wr;
            logic [DATA_W-1:0] val_q;

            assign hit_wr = commit_wr && (addr_q == ADDR_W'(g));

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    val_q <= RST_VAL;
`ifdef REG_BANK_W1C_EN
                end else if (W1C_EFF[g]) begin
                    // Set is ORed after the clear so hardware events are never lost.
                    val_q <= (val_q & ~(hit_wr ? wdata_q : '0)) | hw_set_i[g*DATA_W +: DATA_W];
`endif
                end else if (hit_wr) begin
                    val_q <= wdata_q;
                end
            end

            assign rd_flat[g*DATA_W +: DATA_W] = val_q;
            assign reg_q_o[g*DATA_W +: DATA_W] = val_q;
        end
    end

endmodule

// File: tb/tb_apb_register_bank.sv
// tb_apb_register_bank: two bank instances (WAIT 0 plain RW, WAIT 3 with RO/W1C) checked against an array model.
module tb_apb_register_bank;

    localparam int         WAIT_A  = 0;
    localparam int         WAIT_B  = 3;
    localparam logic [3:0] RO_B    = 4'b0100;
    localparam logic [3:0] W1C_B   = 4'b0010;
    localparam int         TIMEOUT = 20;
`ifdef REG_BANK_W1C_EN
    localparam logic [3:0] W1C_ON  = W1C_B;
`else
    localparam logic [3:0] W1C_ON  = 4'b0000;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        sel = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  addr_d = '0;
    logic [7:0]  wdata_d = '0;
    logic [7:0]  a_data, b_data, o_data;
    logic        a_wd, a_rd, a_err, b_wd, b_rd, b_err, o_wd, o_rd, o_err;
    logic [31:0] a_q, b_q, o_q;
    logic [31:0] b_hw_set = '0;
    logic [31:0] b_hw_status;
    logic [7:0]  hws [4];

    logic [7:0]  mem [2][4];
    logic [7:0]  last_rd [2];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk_i = ~clk_i;

    assign b_hw_status = {hws[3], hws[2], hws[1], hws[0]};
    assign o_data = sel ? b_data : a_data;
    assign o_wd   = sel ? b_wd   : a_wd;
    assign o_rd   = sel ? b_rd   : a_rd;
    assign o_err  = sel ? b_err  : a_err;
    assign o_q    = sel ? b_q    : a_q;

    apb_register_bank #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(4), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .reg_addr_i(addr_d), .reg_data_i(wdata_d), .reg_data_o(a_data),
        .reg_wr_en_i(wr_en & ~sel), .reg_rd_en_i(rd_en & ~sel), .reg_wr_done_o(a_wd), .reg_rd_done_o(a_rd),
        .reg_err_o(a_err), .hw_status_i(32'h0), .hw_set_i(32'h0), .reg_q_o(a_q));

    apb_register_bank #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(4), .WAIT_CYCLES(WAIT_B), .RO_MASK(RO_B),
                        .W1C_MASK(W1C_B)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .reg_addr_i(addr_d), .reg_data_i(wdata_d), .reg_data_o(b_data),
        .reg_wr_en_i(wr_en & sel), .reg_rd_en_i(rd_en & sel), .reg_wr_done_o(b_wd), .reg_rd_done_o(b_rd),
        .reg_err_o(b_err), .hw_status_i(b_hw_status), .hw_set_i(b_hw_set), .reg_q_o(b_q));

    // ---------------- reference model ----------------
    function automatic bit ro_of(input bit s, input int a);
        return s && RO_B[a] && !W1C_ON[a];
    endfunction

    function automatic logic [31:0] exp_q(input bit s);
        logic [31:0] q;
        q = '0;
        for (int a = 0; a < 4; a++) q[a*8 +: 8] = ro_of(s, a) ? 8'h00 : mem[s][a];
        return q;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            last_rd[s] = 8'h00;
            for (int a = 0; a < 4; a++) mem[s][a] = 8'h00;
        end
    endtask

    task automatic model_access(input bit s, input bit wr, input bit rd, input int a, input logic [7:0] d,
                                output logic e_wd, output logic e_rd, output logic e_err, output logic [7:0] e_data);
        e_wd  = wr;
        e_rd  = rd && !wr;
        e_err = 1'b0;
        if (wr) begin
            if (a >= 4 || ro_of(s, a)) e_err = 1'b1;
            else if (s && W1C_ON[a]) mem[s][a] = mem[s][a] & ~d;
            else mem[s][a] = d;
        end else if (a >= 4) begin
            e_err = 1'b1;
            last_rd[s] = 8'h00;
        end else begin
            last_rd[s] = ro_of(s, a) ? hws[a] : mem[s][a];
        end
        e_data = last_rd[s];
    endtask

    // Drive one access, wait (bounded) for its done pulse, then sample the following cycle.
    task automatic access(input bit wr, input bit rd, input logic [7:0] addr, input logic [7:0] data,
                          output int lat, output logic wd, output logic rdn, output logic er,
                          output logic [7:0] rdata, output logic tail);
        @(negedge clk_i);
        wr_en = wr; rd_en = rd; addr_d = addr; wdata_d = data;
        @(posedge clk_i); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        lat = 0; wd = 1'b0; rdn = 1'b0; er = 1'b0; rdata = '0;
        while (lat < TIMEOUT) begin
            @(posedge clk_i); #1;
            lat++;
            if (o_wd || o_rd) begin
                wd = o_wd; rdn = o_rd; er = o_err; rdata = o_data;
                break;
            end
        end
        @(posedge clk_i); #1;
        tail = o_wd | o_rd | o_err;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks++; if (a_q !== exp_q(0)) begin n_fail++; $display("FAIL reset_q_a: got %h want %h", a_q, exp_q(0)); end
        n_checks++; if (b_q !== exp_q(1)) begin n_fail++; $display("FAIL reset_q_b: got %h want %h", b_q, exp_q(1)); end
        n_checks++; if ({a_data, b_data} !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {a_data, b_data}); end
        n_checks++; if ({a_wd, a_rd, a_err, b_wd, b_rd, b_err} !== 6'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0", {a_wd, a_rd, a_err, b_wd, b_rd, b_err}); end
    endtask

    task automatic test_basic();
        int lat; logic wd, rdn, er, tl; logic [7:0] rdata;
        logic e_wd, e_rd, e_err; logic [7:0] e_data;
        sel = 1'b0;
        model_access(0, 1, 0, 0, 8'h32, e_wd, e_rd, e_err, e_data);
        access(1, 0, 8'd0, 8'h32, lat, wd, rdn, er, rdata, tl);
        n_checks++; if (lat !== WAIT_A + 1) begin n_fail++; $display("FAIL basic_wr_latency: got %0d want %0d", lat, WAIT_A + 1); end
        n_checks++; if ({wd, rdn, er} !== 3'b100) begin n_fail++; $display("FAIL basic_wr_flags: got %b want 100", {wd, rdn, er}); end
        n_checks++; if (tl !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b want 0", tl); end
        model_access(0, 0, 1, 0, 8'h00, e_wd, e_rd, e_err, e_data);
        access(0, 1, 8'd0, 8'h00, lat, wd, rdn, er, rdata, tl);
        n_checks++; if (rdata !== 8'h32) begin n_fail++; $display("FAIL basic_rd_data: got %h want 32", rdata); end
        n_checks++; if ({wd, rdn, er, lat} !== {3'b010, 32'(WAIT_A + 1)}) begin n_fail++; $display("FAIL basic_rd_flags: got %b lat %0d want 010 lat %0d", {wd, rdn, er}, lat, WAIT_A + 1); end
    endtask

    task automatic test_all_regs();
        int lat; logic wd, rdn, er, tl; logic [7:0] rdata;
        logic e_wd, e_rd, e_err; logic [7:0] e_data;
        logic [7:0] vals [4];
        vals[0] = 8'h32; vals[1] = 8'h48; vals[2] = 8'h25; vals[3] = 8'h12;
        sel = 1'b0;
        for (int a = 1; a < 4; a++) begin
            model_access(0, 1, 0, a, vals[a], e_wd, e_rd, e_err, e_data);
            access(1, 0, 8'(a), vals[a], lat, wd, rdn, er, rdata, tl);
        end
        for (int a = 0; a < 4; a++) begin
            model_access(0, 0, 1, a, 8'h00, e_wd, e_rd, e_err, e_data);
            access(0, 1, 8'(a), 8'h00, lat, wd, rdn, er, rdata, tl);
            n_checks++; if (rdata !== vals[a]) begin n_fail++; $display("FAIL all_regs_rd%0d: got %h want %h", a, rdata, vals[a]); end
        end
        n_checks++; if (a_q !== 32'h12254832) begin n_fail++; $display("FAIL all_regs_q: got %h want 12254832", a_q); end
    endtask

    task automatic test_out_of_range();
        int lat; logic wd, rdn, er, tl; logic [7:0] rdata;
        logic e_wd, e_rd, e_err; logic [7:0] e_data;
        sel = 1'b0;
        model_access(0, 1, 0, 5, 8'hEE, e_wd, e_rd, e_err, e_data);
        access(1, 0, 8'd5, 8'hEE, lat, wd, rdn, er, rdata, tl);
        n_checks++; if ({wd, er} !== 2'b11) begin n_fail++; $display("FAIL oor_wr_flags: got %b want 11", {wd, er}); end
        n_checks++; if (a_q !== exp_q(0)) begin n_fail++; $display("FAIL oor_wr_q: got %h want %h", a_q, exp_q(0)); end
        model_access(0, 0, 1, 5, 8'h00, e_wd, e_rd, e_err, e_data);
        access(0, 1, 8'd5, 8'h00, lat, wd, rdn, er, rdata, tl);
        n_checks++; if ({rdn, er, rdata} !== {2'b11, 8'h00}) begin n_fail++; $display("FAIL oor_rd: got rd %b err %b data %h want 1 1 00", rdn, er, rdata); end
    endtask

    task automatic test_simultaneous();
        int lat; logic wd, rdn, er, tl; logic [7:0] rdata;
        logic e_wd, e_rd, e_err; logic [7:0] e_data;
        sel = 1'b0;
        model_access(0, 1, 1, 1, 8'h5A, e_wd, e_rd, e_err, e_data);
        access(1, 1, 8'd1, 8'h5A, lat, wd, rdn, er, rdata, tl);
        n_checks++; if ({wd, rdn, er, tl} !== {e_wd, e_rd, e_err, 1'b0}) begin n_fail++; $display("FAIL simul_flags: got %b want %b", {wd, rdn, er, tl}, {e_wd, e_rd, e_err, 1'b0}); end
        n_checks++; if (rdata !== e_data) begin n_fail++; $display("FAIL simul_held_data: got %h want %h", rdata, e_data); end
        n_checks++; if (a_q !== exp_q(0)) begin n_fail++; $display("FAIL simul_q: got %h want %h", a_q, exp_q(0)); end
    endtask

    task automatic test_random(input bit s, input int n);
        int lat; logic wd, rdn, er, tl; logic [7:0] rdata;
        logic e_wd, e_rd, e_err; logic [7:0] e_data;
        bit wr, rd; int a; logic [7:0] d; int e_lat;
        sel = s;
        e_lat = (s ? WAIT_B : WAIT_A) + 1;
        for (int k = 0; k < n; k++) begin
            wr = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 1) == 1) || !wr;
            a  = $urandom_range(0, 6);
            d  = 8'($urandom);
            if (s) hws[2] = 8'($urandom);
            model_access(s, wr, rd, a, d, e_wd, e_rd, e_err, e_data);
            access(wr, rd, 8'(a), d, lat, wd, rdn, er, rdata, tl);
            n_checks++; if (lat !== e_lat) begin n_fail++; $display("FAIL rand%0d_latency[%0d]: got %0d want %0d", s, k, lat, e_lat); end
            n_checks++; if ({wd, rdn, er, tl} !== {e_wd, e_rd, e_err, 1'b0}) begin n_fail++; $display("FAIL rand%0d_flags[%0d]: got %b want %b", s, k, {wd, rdn, er, tl}, {e_wd, e_rd, e_err, 1'b0}); end
            n_checks++; if (rdata !== e_data) begin n_fail++; $display("FAIL rand%0d_data[%0d]: got %h want %h", s, k, rdata, e_data); end
            n_checks++; if (o_q !== exp_q(s)) begin n_fail++; $display("FAIL rand%0d_q[%0d]: got %h want %h", s, k, o_q, exp_q(s)); end
        end
    endtask

    task automatic test_wait();
        int lat; bit seen; bit extra;
        logic e_wd, e_rd, e_err; logic [7:0] e_data;
        sel = 1'b1;
        model_access(1, 1, 0, 0, 8'h11, e_wd, e_rd, e_err, e_data);
        @(negedge clk_i); wr_en = 1'b1; addr_d = 8'd0; wdata_d = 8'h11;
        @(posedge clk_i); #1; wr_en = 1'b0;
        @(negedge clk_i); wr_en = 1'b1; wdata_d = 8'h99;
        @(posedge clk_i); #1; wr_en = 1'b0;
        lat = 1; seen = 1'b0;
        while (lat < TIMEOUT && !seen) begin
            @(posedge clk_i); #1;
            lat++;
            seen = o_wd;
        end
        n_checks++; if (lat !== WAIT_B + 1) begin n_fail++; $display("FAIL wait_latency: got %0d want %0d", lat, WAIT_B + 1); end
        extra = 1'b0;
        repeat (10) begin @(posedge clk_i); #1; extra |= (o_wd | o_rd); end
        n_checks++; if (extra !== 1'b0) begin n_fail++; $display("FAIL wait_ignored_enable: got extra done %b want 0", extra); end
        n_checks++; if (b_q !== exp_q(1)) begin n_fail++; $display("FAIL wait_q: got %h want %h", b_q, exp_q(1)); end
    endtask

    task automatic test_ro();
        int lat; logic wd, rdn, er, tl; logic [7:0] rdata;
        logic e_wd, e_rd, e_err; logic [7:0] e_data;
        sel = 1'b1;
        hws[2] = 8'hA5;
        model_access(1, 0, 1, 2, 8'h00, e_wd, e_rd, e_err, e_data);
        access(0, 1, 8'd2, 8'h00, lat, wd, rdn, er, rdata, tl);
        n_checks++; if ({rdata, er} !== {8'hA5, 1'b0}) begin n_fail++; $display("FAIL ro_rd1: got %h err %b want a5 err 0", rdata, er); end
        model_access(1, 1, 0, 2, 8'hFF, e_wd, e_rd, e_err, e_data);
        access(1, 0, 8'd2, 8'hFF, lat, wd, rdn, er, rdata, tl);
        n_checks++; if ({wd, er} !== 2'b11) begin n_fail++; $display("FAIL ro_wr_err: got %b want 11", {wd, er}); end
        n_checks++; if (b_q !== exp_q(1)) begin n_fail++; $display("FAIL ro_q: got %h want %h", b_q, exp_q(1)); end
        model_access(1, 0, 1, 2, 8'h00, e_wd, e_rd, e_err, e_data);
        access(0, 1, 8'd2, 8'h00, lat, wd, rdn, er, rdata, tl);
        n_checks++; if ({rdata, er} !== {8'hA5, 1'b0}) begin n_fail++; $display("FAIL ro_rd2: got %h err %b want a5 err 0", rdata, er); end
    endtask

    task automatic test_reset_in_wait();
        bit extra;
        sel = 1'b1;
        @(negedge clk_i); wr_en = 1'b1; addr_d = 8'd3; wdata_d = 8'h77;
        @(posedge clk_i); #1; wr_en = 1'b0;
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        n_checks++; if (b_data !== 8'h00) begin n_fail++; $display("FAIL rstwait_data: got %h want 00", b_data); end
        n_checks++; if ({b_q, a_q} !== {exp_q(1), exp_q(0)}) begin n_fail++; $display("FAIL rstwait_q: got %h %h want 0", b_q, a_q); end
        n_checks++; if ({b_wd, b_rd, b_err} !== 3'b000) begin n_fail++; $display("FAIL rstwait_pulses: got %b want 000", {b_wd, b_rd, b_err}); end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        extra = 1'b0;
        repeat (10) begin @(posedge clk_i); #1; extra |= (b_wd | b_rd | b_err); end
        n_checks++; if (extra !== 1'b0) begin n_fail++; $display("FAIL rstwait_dropped: got done %b want 0", extra); end
    endtask

    task automatic test_w1c();
        int lat; logic wd, rdn, er, tl; logic [7:0] rdata;
        logic e_wd, e_rd, e_err; logic [7:0] e_data;
        sel = 1'b1;
`ifdef REG_BANK_W1C_EN
        @(negedge clk_i); b_hw_set = 32'h0000F000;
        @(negedge clk_i); b_hw_set = 32'h0;
        mem[1][1] = mem[1][1] | 8'hF0;
        n_checks++; if (b_q[15:8] !== 8'hF0) begin n_fail++; $display("FAIL w1c_set: got %h want f0", b_q[15:8]); end
        model_access(1, 1, 0, 1, 8'h30, e_wd, e_rd, e_err, e_data);
        access(1, 0, 8'd1, 8'h30, lat, wd, rdn, er, rdata, tl);
        model_access(1, 0, 1, 1, 8'h00, e_wd, e_rd, e_err, e_data);
        access(0, 1, 8'd1, 8'h00, lat, wd, rdn, er, rdata, tl);
        n_checks++; if (rdata !== 8'hC0) begin n_fail++; $display("FAIL w1c_clear: got %h want c0", rdata); end
        // set bit7 only in the cycle whose edge commits a write-1 to bit7
        @(negedge clk_i); wr_en = 1'b1; addr_d = 8'd1; wdata_d = 8'h80;
        @(posedge clk_i); #1; wr_en = 1'b0;
        repeat (WAIT_B) @(posedge clk_i);
        @(negedge clk_i); b_hw_set = 32'h00008000;
        @(posedge clk_i); #1;
        n_checks++; if ({b_wd, b_q[15:8]} !== {1'b1, 8'hC0}) begin n_fail++; $display("FAIL w1c_set_wins: got done %b val %h want 1 c0", b_wd, b_q[15:8]); end
        @(negedge clk_i); b_hw_set = 32'h0;
        model_access(1, 1, 0, 1, 8'h80, e_wd, e_rd, e_err, e_data);
        access(1, 0, 8'd1, 8'h80, lat, wd, rdn, er, rdata, tl);
        n_checks++; if (b_q !== exp_q(1)) begin n_fail++; $display("FAIL w1c_q: got %h want %h", b_q, exp_q(1)); end
`else
        model_access(1, 1, 0, 1, 8'hF0, e_wd, e_rd, e_err, e_data);
        access(1, 0, 8'd1, 8'hF0, lat, wd, rdn, er, rdata, tl);
        model_access(1, 1, 0, 1, 8'h30, e_wd, e_rd, e_err, e_data);
        access(1, 0, 8'd1, 8'h30, lat, wd, rdn, er, rdata, tl);
        n_checks++; if (b_q !== exp_q(1)) begin n_fail++; $display("FAIL plain_rw_q: got %h want %h", b_q, exp_q(1)); end
`endif
        model_access(1, 0, 1, 1, 8'h00, e_wd, e_rd, e_err, e_data);
        access(0, 1, 8'd1, 8'h00, lat, wd, rdn, er, rdata, tl);
        n_checks++; if (rdata !== e_data) begin n_fail++; $display("FAIL reg1_final_rd: got %h want %h", rdata, e_data); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hws[i] = 8'h00;
        test_reset();
        test_basic();
        test_all_regs();
        test_out_of_range();
        test_simultaneous();
        test_random(1'b0, 40);
        test_wait();
        test_random(1'b1, 30);
        test_ro();
        test_reset_in_wait();
        test_w1c();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
